// File: rtl/multiplicador_if.sv
// Operand/result handshake between the control unit and the MULT datapath.
// Build option MULT_UNSIGNED_EN adds the multU unsigned-select signal.
interface multiplicador_if #(
   parameter int N_BITS = 32
);
   logic              multOp;
   logic [N_BITS-1:0] multiplicand;
   logic [N_BITS-1:0] multiplier;
   logic [N_BITS-1:0] mult_hi;
   logic [N_BITS-1:0] mult_lo;
   logic              mult_busy;
   logic              mult_done;
`ifdef MULT_UNSIGNED_EN
   logic              multU;
`endif

   modport master (
`ifdef MULT_UNSIGNED_EN
      output multU,
`endif
      output multOp, multiplicand, multiplier,
      input  mult_hi, mult_lo, mult_busy, mult_done
   );

   modport slave (
`ifdef MULT_UNSIGNED_EN
      input  multU,
`endif
      input  multOp, multiplicand, multiplier,
      output mult_hi, mult_lo, mult_busy, mult_done
   );
endinterface

// File: rtl/multiplicador.sv
// Iterative N_BITS x N_BITS -> 2*N_BITS radix-2 Booth multiplier, one step per clock.
// Build option MULT_UNSIGNED_EN adds an unsigned shift-add mode selected by multU.
module multiplicador #(
   parameter int N_BITS = 32
) (
   input  logic           clk,
   input  logic           reset,
   multiplicador_if.slave bus
);
   localparam int CW = $clog2(N_BITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_BITS-1:0] m_q, m_d;
   logic [N_BITS-1:0] q_q, q_d;
   logic [N_BITS-1:0] hi_q, hi_d;
   logic [N_BITS-1:0] lo_q, lo_d;
   logic [N_BITS:0]   a_q, a_d;
   logic [N_BITS:0]   m_ext_s;
   logic [N_BITS:0]   sum_s;
   logic              shift_msb_s;
   logic              qm1_q, qm1_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CW-1:0]     count_q, count_d;
`ifdef MULT_UNSIGNED_EN
   logic              u_q, u_d;
`endif

   // One add/subtract step; A is one bit wider so subtracting the most negative M cannot overflow.
   always_comb begin
      m_ext_s = {m_q[N_BITS-1], m_q};
      case ({q_q[0], qm1_q})
         2'b01:   sum_s = a_q + m_ext_s;
         2'b10:   sum_s = a_q - m_ext_s;
         default: sum_s = a_q;
      endcase
      shift_msb_s = sum_s[N_BITS];
`ifdef MULT_UNSIGNED_EN
      if (u_q) begin
         m_ext_s     = {1'b0, m_q};
         sum_s       = q_q[0] ? (a_q + m_ext_s) : a_q;
         shift_msb_s = 1'b0;
      end else begin
         shift_msb_s = sum_s[N_BITS];
      end
`endif
   end

   // Sequencing and next values of all datapath registers.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      a_d     = a_q;
      qm1_d   = qm1_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MULT_UNSIGNED_EN
      u_d     = u_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.multOp) begin
               m_d     = bus.multiplicand;
               q_d     = bus.multiplier;
               a_d     = {(N_BITS+1){1'b0}};
               qm1_d   = 1'b0;
               count_d = CW'(N_BITS - 1);
`ifdef MULT_UNSIGNED_EN
               u_d     = bus.multU;
`endif
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = {shift_msb_s, sum_s[N_BITS:1]};
            q_d   = {sum_s[0], q_q[N_BITS-1:1]};
            qm1_d = q_q[0];
            if (count_q == {CW{1'b0}}) begin
               state_d = DONE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         DONE: begin
            hi_d    = a_q[N_BITS-1:0];
            lo_d    = q_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         m_q     <= {N_BITS{1'b0}};
         q_q     <= {N_BITS{1'b0}};
         a_q     <= {(N_BITS+1){1'b0}};
         qm1_q   <= 1'b0;
         count_q <= {CW{1'b0}};
         hi_q    <= {N_BITS{1'b0}};
         lo_q    <= {N_BITS{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULT_UNSIGNED_EN
         u_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         a_q     <= a_d;
         qm1_q   <= qm1_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MULT_UNSIGNED_EN
         u_q     <= u_d;
`endif
      end
   end

   assign bus.mult_hi   = hi_q;
   assign bus.mult_lo   = lo_q;
   assign bus.mult_busy = busy_q;
   assign bus.mult_done = done_q;
endmodule
